timer_device: RTL and testbench
===============================

TIMER_DEVICE -- requirements
Module: timer_device

Interface
REQ-001 SHALL have parameter PRESET_RST, default 32'h0000_0000, reset value of PRESET.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Addr  input  30  word address [31:2]; only Addr[3:2] decoded.
REQ-005 SHALL have port WD  input  32  write data.
REQ-006 SHALL have port WE  input  1  word write enable, pre-qualified by upstream address decode.
REQ-007 SHALL have port RD  output  32  combinational read data.
REQ-008 SHALL have port IRQ  output  1  interrupt request, level, registered.

Function
REQ-009 SHALL map Addr[3:2]: 00 CTRL, 01 PRESET, 10 COUNT (read-only), 11 reads 32'h0; writes to 10/11 ignored.
REQ-010 SHALL define CTRL[0] En, CTRL[2:1] Mode, CTRL[3] IM; CTRL[31:4] read 0, writes ignored.
REQ-011 SHALL return current register value on RD with zero latency, no side effects on read.
REQ-012 SHALL implement FSM IDLE, LOAD, CNT, INT; reset state IDLE.
REQ-013 IDLE: En=1 -> LOAD next edge; else stay, COUNT held.
REQ-014 LOAD: COUNT<=PRESET, -> CNT.
REQ-015 CNT: En=0 -> IDLE, COUNT held; COUNT>1 -> COUNT-1; COUNT<=1 -> COUNT<=0, irq_flag<=1, -> INT.
REQ-016 INT, Mode 00: En<=0, irq_flag held, -> IDLE; irq_flag clears only on a CTRL write.
REQ-017 INT, Mode 01: irq_flag<=0 (one-cycle pulse), -> IDLE, auto-reload since En stays 1.
REQ-018 SHALL treat Mode 10/11 as Mode 00.
REQ-019 SHALL count PRESET=0 and PRESET=1 identically: interrupt on first CNT cycle.
REQ-020 SHALL make IRQ assert N+2 edges after the CTRL write edge that sets En with PRESET=N>=1; Mode 01 period N+3 cycles.
REQ-021 SHALL give a same-edge CPU CTRL write priority over FSM CTRL update (En clear in INT) and clear irq_flag.
REQ-022 SHALL not disturb an in-progress count on PRESET write; new value takes effect at next LOAD.
REQ-023 SHALL not wrap COUNT: decrement never below 0.

Reset
REQ-024 SHALL on reset=0 immediately set CTRL=0, COUNT=0, PRESET=PRESET_RST, irq_flag=0, IRQ=0, state IDLE, regardless of clk.
REQ-025 SHALL abort any count on mid-operation reset; no IRQ until re-enabled after release.
REQ-026 SHALL resume operation on first rising edge after reset=1.

Configuration
REQ-027 SHALL support macro TIMER_IRQ_MASK_EN.
REQ-028 Defined: CTRL[3] IM read/write, IRQ = irq_flag & IM.
REQ-029 Undefined: CTRL[3] reads 0, writes ignored, IRQ = irq_flag.

Verification
REQ-030 Reset, read all addresses -> RD=0 (PRESET=PRESET_RST), IRQ=0, state IDLE.
REQ-031 PRESET=5, CTRL=32'h9 (En, Mode 00, IM) -> COUNT 5,4,3,2,1,0; IRQ high at 7th edge after write, stays high; CTRL reads 32'h8; IRQ falls after write CTRL=32'h8.
REQ-032 PRESET=3, CTRL=32'hB (Mode 01) -> IRQ one-cycle pulses every 6 cycles, En stays 1.
REQ-033 Mid-count write CTRL=0 at COUNT=3 -> COUNT holds 3, no IRQ; write PRESET=9 mid-count -> current count unaffected.
REQ-034 Assert reset at COUNT=2 with IRQ pending -> all outputs 0 before next clk edge.
REQ-035 Macro undefined: CTRL=32'h1, PRESET=2 -> IRQ high at 4th edge; CTRL reads 32'h0 after INT.

Source files
------------

// File: rtl/timer_device.sv
// timer_device: memory-mapped down-counting timer with one-shot or auto-reload interrupt.
// Define TIMER_IRQ_MASK_EN to make CTRL[3] a stored interrupt mask gating IRQ.
module timer_device #(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  output logic        IRQ
);
`ifdef TIMER_IRQ_MASK_EN
  localparam logic [3:0] CTRL_MASK = 4'hf;
`else
  localparam logic [3:0] CTRL_MASK = 4'h7;
`endif
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  state_t state, state_nx;
  logic [3:0] ctrl;
  logic [31:0] preset, count, count_nx;
  logic irq_flag, flag_nx, en_clr, ctrl_we, preset_we;
  logic unused;
  assign unused = ^{Addr[31:4], WD[31:4]};
  assign ctrl_we = WE && Addr[3:2] == 2'b00;
  assign preset_we = WE && Addr[3:2] == 2'b01;
  always_comb begin
    state_nx = state;
    count_nx = count;
    flag_nx = irq_flag;
    en_clr = 1'b0;
    case (state)
      IDLE: state_nx = ctrl[0] ? LOAD : IDLE;
      LOAD: begin
        count_nx = preset;
        state_nx = CNT;
      end
      CNT: begin
        state_nx = !ctrl[0] ? IDLE : count > 32'd1 ? CNT : INT;
        count_nx = !ctrl[0] ? count : count > 32'd1 ? count - 32'd1 : 32'd0;
        flag_nx = irq_flag | (ctrl[0] && count <= 32'd1);
      end
      INT: begin
        state_nx = IDLE;
        flag_nx = ctrl[2:1] == 2'b01 ? 1'b0 : irq_flag;
        en_clr = ctrl[2:1] != 2'b01;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // A CPU write to CTRL overrides the FSM's En clear and always drops the flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl <= 4'h0;
      preset <= PRESET_RST;
      count <= 32'h0;
      irq_flag <= 1'b0;
    end else begin
      count <= count_nx;
      if (preset_we) preset <= WD;
      if (ctrl_we) begin
        ctrl <= WD[3:0] & CTRL_MASK;
        irq_flag <= 1'b0;
      end else begin
        ctrl[0] <= ctrl[0] & ~en_clr;
        irq_flag <= flag_nx;
      end
    end
  end
  always_comb
    RD = Addr[3:2] == 2'b00 ? {28'h0, ctrl} :
         Addr[3:2] == 2'b01 ? preset :
         Addr[3:2] == 2'b10 ? count : 32'h0;
`ifdef TIMER_IRQ_MASK_EN
  assign IRQ = irq_flag & ctrl[3];
`else
  assign IRQ = irq_flag;
`endif
endmodule

// File: tb/tb_timer_device.sv
// tb_timer_device: random scenarios checked against a closed-form timing model of the timer.
module tb_timer_device;
  localparam logic [31:0] PR = 32'h0000_0000;
`ifdef TIMER_IRQ_MASK_EN
  localparam logic [31:0] MASK = 32'hf;
  localparam bit IM_ON = 1'b1;
`else
  localparam logic [31:0] MASK = 32'h7;
  localparam bit IM_ON = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, WE = 1'b0, IRQ;
  logic [31:2] Addr = '0;
  logic [31:0] WD = '0, RD;
  int errors = 0, checks = 0, cur_k = 0;

  timer_device #(.PRESET_RST(PR)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WD(WD), .WE(WE), .RD(RD), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (k=%0d): got %h expected %h", tag, cur_k, got, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = {28'($urandom), a};
    #1;
    d = RD;
  endtask

  task automatic wr_setup(input logic [1:0] a, input logic [31:0] d);
    Addr = {28'($urandom), a};
    WD = d;
    WE = 1'b1;
  endtask

  // COUNT r cycles into a run (r=0 is the enabling edge), starting from COUNT=0.
  function automatic int cnt(input int n, input int r);
    return r < 2 ? 0 : (n - (r - 2) > 0 ? n - (r - 2) : 0);
  endfunction

  task automatic check_all_zero(input string tag);
    logic [31:0] d;
    rd(2'b00, d); chk({tag, "_ctrl"}, d, 32'h0);
    rd(2'b01, d); chk({tag, "_preset"}, d, PR);
    rd(2'b10, d); chk({tag, "_count"}, d, 32'h0);
    rd(2'b11, d); chk({tag, "_rsvd"}, d, 32'h0);
    chk({tag, "_irq"}, {31'h0, IRQ}, 32'h0);
  endtask

  // kp: PRESET<=9 edge, ks: CTRL<=0 edge, kc: CTRL<=8 edge, kr: async reset after edge kr (-1 = none)
  task automatic scenario(input int n, input int mode, input int im,
                          input int kp, input int ks, input int kc, input int kr);
    int ne, p, l;
    logic [31:0] w, d, ec, ectl;
    logic ef, stopped, cleared;
    ne = n < 1 ? 1 : n;
    p = ne + 3;
    l = 2 * p + 4;
    w = {28'h0, im[0], mode[1:0], 1'b1} & MASK;
    @(negedge clk);
    reset = 1'b0;
    WE = 1'b0;
    cur_k = -1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    wr_setup(2'b01, 32'(n));
    @(negedge clk);
    wr_setup(2'b00, w | 32'hffff_fff0);
    for (int k = 0; k < l; k++) begin
      @(negedge clk);
      WE = 1'b0;
      cur_k = k;
      if (k == kr) begin
        reset = 1'b0;
        check_all_zero("midreset");
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
          @(negedge clk);
          rd(2'b10, d);
          chk("post_reset_count", d, 32'h0);
          chk("post_reset_irq", {31'h0, IRQ}, 32'h0);
        end
        return;
      end
      stopped = ks >= 0 && k >= ks;
      cleared = kc >= 0 && k >= kc;
      ec = 32'(stopped ? cnt(n, ks) : mode == 1 ? cnt(n, k % p) : cnt(n, k));
      ef = stopped || cleared ? 1'b0 : mode == 1 ? (k % p == ne + 2) : (k >= ne + 2);
      ectl = stopped ? 32'h0 : cleared ? (32'h8 & MASK) :
             (mode != 1 && k >= ne + 3) ? (w & ~32'h1) : w;
      rd(2'b10, d);
      chk("count", d, ec);
      rd(2'b00, d);
      chk("ctrl", d, ectl);
      rd(2'b11, d);
      chk("rsvd", d, 32'h0);
      chk("irq", {31'h0, IRQ}, {31'h0, ef & (IM_ON ? w[3] : 1'b1)});
      if (k + 1 == kp) wr_setup(2'b01, 32'd9);
      if (k + 1 == ks) wr_setup(2'b00, 32'h0);
      if (k + 1 == kc) wr_setup(2'b00, 32'h8);
    end
    @(negedge clk);
    WE = 1'b0;
    rd(2'b01, d);
    chk("preset", d, kp >= 0 ? 32'd9 : 32'(n));
  endtask

  initial begin
    int n, mode, ne, l, kp, ks, kc, kr;
    reset = 1'b0;
    #1;
    check_all_zero("por");
    scenario(5, 0, 1, -1, -1, 12, -1);
    scenario(3, 1, 1, -1, -1, -1, -1);
    scenario(5, 0, 0, 3, 4, -1, -1);
    scenario(5, 0, 1, -1, -1, -1, 5);
    scenario(5, 0, 1, -1, -1, -1, 9);
    scenario(2, 0, 0, -1, -1, 7, -1);
    scenario(0, 0, 1, -1, -1, 9, -1);
    scenario(1, 1, 0, -1, -1, -1, -1);
    scenario(4, 0, 1, -1, -1, 7, -1);
    scenario(6, 3, 1, -1, -1, 11, -1);
    for (int i = 0; i < 16; i++) begin
      n = $urandom_range(0, 12);
      mode = $urandom_range(0, 3);
      ne = n < 1 ? 1 : n;
      l = 2 * (ne + 3) + 4;
      kp = -1; ks = -1; kc = -1;
      if (mode != 1) begin
        if ($urandom_range(0, 1) == 1 && n >= 2) ks = $urandom_range(3, ne + 1);
        if ($urandom_range(0, 1) == 1) kp = $urandom_range(2, ne + 2);
        if (kp == ks) kp = -1;
        if (ks < 0) kc = $urandom_range(ne + 3, l - 2);
      end
      kr = $urandom_range(0, 3) == 0 ? $urandom_range(0, l - 1) : -1;
      scenario(n, mode, $urandom_range(0, 1), kp, ks, kc, kr);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
